// File: rtl/attn_softmax_stream_pkg.sv
// Shared fixed-point constants, helper function and FSM encoding for the
// attention softmax stream stage.
package attn_softmax_stream_pkg;

  localparam int FIX_FRAC = 8;
  localparam int FIX_ONE  = 1 << FIX_FRAC;

  // Ceiling log2; returns 0 for values <= 1.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ROW  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/attn_softmax_stream_softmax_row.sv
// Combinational fixed-point softmax of one score row using a shift-based exp
// and a single reciprocal divide shared by all elements of the row.
module softmax_row
  import attn_softmax_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC       = FIX_FRAC,
  parameter int TOKEN_NUM  = 8
) (
  input  logic [DATA_WIDTH*TOKEN_NUM-1:0] x,
  input  logic [TOKEN_NUM-1:0]            active,
  output logic [DATA_WIDTH*TOKEN_NUM-1:0] s
);

  localparam int DW = DATA_WIDTH;
  localparam int EW = FRAC + 1;
  localparam int SW = FRAC + 1 + clog2(TOKEN_NUM);
  localparam int NW = (2 * FRAC + 1 > SW) ? 2 * FRAC + 1 : SW;
  localparam int PW = 2 * EW;

  logic signed [DW-1:0] xv   [TOKEN_NUM];
  logic        [DW:0]   d    [TOKEN_NUM];
  logic        [DW:0]   k    [TOKEN_NUM];
  logic        [EW-1:0] e    [TOKEN_NUM];
  logic        [PW-1:0] prod [TOKEN_NUM];
  logic signed [DW-1:0] m;
  logic        [SW-1:0] sum;
  logic        [NW-1:0] num;
  logic        [NW-1:0] quo;
  logic        [EW-1:0] recip;

  always_comb begin
    for (int j = 0; j < TOKEN_NUM; j++) begin
      xv[j] = signed'(x[j*DW +: DW]);
    end

    // Column 0 is never masked, so it seeds the running max.
    m = xv[0];
    for (int j = 1; j < TOKEN_NUM; j++) begin
      if (active[j] && (xv[j] > m)) begin
        m = xv[j];
      end
    end

    sum = '0;
    for (int j = 0; j < TOKEN_NUM; j++) begin
      d[j] = {m[DW-1], m} - {xv[j][DW-1], xv[j]};
      k[j] = d[j] >> FRAC;
      if (active[j] && (k[j] <= (DW+1)'(FRAC))) begin
        e[j] = (EW'(1) << FRAC) >> k[j];
      end else begin
        e[j] = '0;
      end
      sum = sum + SW'(e[j]);
    end

    // The max element always contributes 1.0, so sum is never zero.
    num   = NW'(1) << (2 * FRAC);
    quo   = num / NW'(sum);
    recip = EW'(quo);

    s = '0;
    for (int j = 0; j < TOKEN_NUM; j++) begin
      prod[j]        = PW'(e[j]) * PW'(recip);
      s[j*DW +: DW]  = DW'(prod[j] >> FRAC);
    end
  end

endmodule

// File: rtl/attn_softmax_stream.sv
// Accepts a score/value matrix pair, computes the row softmax one row per
// cycle and holds S/V for the weighted-sum stage until it is taken.
module attn_softmax_stream
  import attn_softmax_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC       = FIX_FRAC,
  parameter int TOKEN_DIM  = 4,
  parameter int TOKEN_NUM  = 8
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  input  logic                                     mask_en,
  input  logic [DATA_WIDTH*TOKEN_NUM*TOKEN_NUM-1:0] A_in,
  input  logic [DATA_WIDTH*TOKEN_DIM*TOKEN_NUM-1:0] V_in,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic [DATA_WIDTH*TOKEN_NUM*TOKEN_NUM-1:0] S_out,
  output logic [DATA_WIDTH*TOKEN_DIM*TOKEN_NUM-1:0] V_out
);

  localparam int RW  = clog2(TOKEN_NUM);
  localparam int RSW = DATA_WIDTH * TOKEN_NUM;
  localparam int AW  = RSW * TOKEN_NUM;
  localparam int VW  = DATA_WIDTH * TOKEN_DIM * TOKEN_NUM;
  localparam logic [RW-1:0] LAST_ROW = RW'(TOKEN_NUM - 1);

  // Handshake: a transfer happens on any rising edge where valid and ready
  // are both high; valid, once raised, holds its payload until ready.
  state_t         state;
  logic [RW-1:0]  row;
  logic [AW-1:0]  a_reg;
  logic [VW-1:0]  v_reg;
  logic           mask_reg;
  logic [AW-1:0]  s_buf;

  logic [RSW-1:0]       row_x;
  logic [RSW-1:0]       row_s;
  logic [TOKEN_NUM-1:0] row_active;

  always_comb begin
    row_x = a_reg[int'(row)*RSW +: RSW];
    for (int j = 0; j < TOKEN_NUM; j++) begin
      row_active[j] = !mask_reg || (j <= int'(row));
    end
  end

  softmax_row #(
    .DATA_WIDTH (DATA_WIDTH),
    .FRAC       (FRAC),
    .TOKEN_NUM  (TOKEN_NUM)
  ) u_row (
    .x      (row_x),
    .active (row_active),
    .s      (row_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      row       <= '0;
      a_reg     <= '0;
      v_reg     <= '0;
      mask_reg  <= 1'b0;
      s_buf     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            a_reg    <= A_in;
            v_reg    <= V_in;
            mask_reg <= mask_en;
            row      <= '0;
            in_ready <= 1'b0;
            state    <= ST_ROW;
          end
        end
        ST_ROW: begin
          s_buf[int'(row)*RSW +: RSW] <= row_s;
          if (row == LAST_ROW) begin
            row       <= '0;
            out_valid <= 1'b1;
            state     <= ST_DONE;
          end else begin
            row <= row + 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state     <= ST_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign S_out = s_buf;
  assign V_out = v_reg;

endmodule
